// File: rtl/conv_pkg.sv
// ============================================================================
// Module  : conv_pkg
// Purpose : Shared widths, FSM encoding, tap geometry and the tap packing
//           helper for the 3x3 convolution scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int DW_DEF   = 16;
    localparam int PW_DEF   = 32;
    localparam int SW_DEF   = 36;

    localparam int TAP_ROWS = 3;
    localparam int TAP_COLS = 3;
    localparam int NUM_TAPS = TAP_ROWS * TAP_COLS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Zero-based tap k occupies [tap_lo(k,w) +: w] of a flat tap bus.
    function automatic int tap_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// ============================================================================
// Module  : conv_line_buffer
// Purpose : DEPTH-entry shift buffer; dout is the value shifted in DEPTH
//           enabled cycles earlier (one image row of delay).
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_line_buffer #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (shift_en) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
        end
    end

    assign dout = r_mem[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/conv3x3_scheduler.sv
// ============================================================================
// Module  : conv3x3_scheduler
// Purpose : Builds 3x3 windows from a raster stream, feeds the external
//           nine-lane multiplier layer and sums its products per window.
//           Optional macro CONV_SAT_EN saturates the sum at 2^32-1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv3x3_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = DW_DEF,
    parameter int PW    = PW_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   w_we,
    input  logic [3:0]             w_addr,
    input  logic [DW-1:0]          w_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    output logic [NUM_TAPS*DW-1:0] win_flat,
    output logic [NUM_TAPS*DW-1:0] wt_flat,
    input  logic [NUM_TAPS*PW-1:0] prod_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SW-1:0]          out_data,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic [DW-1:0] r_wt      [NUM_TAPS];
    logic [DW-1:0] r_win     [NUM_TAPS];
    logic [DW-1:0] w_win_nxt [NUM_TAPS];
    logic [DW-1:0] r_hist    [TAP_ROWS][2];
    logic [DW-1:0] w_col_now [TAP_ROWS];
    logic [DW-1:0] w_lb0_out, w_lb1_out;

    logic          r_s1_valid, r_s2_valid;
    logic [SW-1:0] r_sum, w_sum_raw, w_sum;
    logic          w_s2_free, w_s1_adv, w_accept, w_win_done, w_last_px;

    assign w_s2_free  = !r_s2_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign in_ready   = (r_state == ST_RUN) && (!r_s1_valid || w_s2_free);
    assign w_accept   = in_valid && in_ready;
    assign w_win_done = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_last_px  = (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);

    conv_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_accept),
        .din      (in_data),
        .dout     (w_lb0_out)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_accept),
        .din      (w_lb0_out),
        .dout     (w_lb1_out)
    );

    // Row 0 is the oldest row; within a row the oldest column comes first.
    always_comb begin
        w_col_now[0] = w_lb1_out;
        w_col_now[1] = w_lb0_out;
        w_col_now[2] = in_data;
        for (int r = 0; r < TAP_ROWS; r++) begin
            w_win_nxt[r*TAP_COLS + 0] = r_hist[r][1];
            w_win_nxt[r*TAP_COLS + 1] = r_hist[r][0];
            w_win_nxt[r*TAP_COLS + 2] = w_col_now[r];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        frame_done  = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && w_last_px) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!r_s1_valid && !r_s2_valid) begin
                    w_state_nxt = ST_IDLE;
                    frame_done  = 1'b1;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            for (int k = 0; k < NUM_TAPS; k++) r_wt[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_col <= '0;
                    r_row <= '0;
                end
                if (w_we && (w_addr < 4'(NUM_TAPS))) r_wt[w_addr] <= w_data;
            end else if (w_accept) begin
                if (r_col == C_COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) r_win[k] <= '0;
            for (int r = 0; r < TAP_ROWS; r++) begin
                r_hist[r][0] <= '0;
                r_hist[r][1] <= '0;
            end
        end else if (w_accept) begin
            for (int r = 0; r < TAP_ROWS; r++) begin
                r_hist[r][1] <= r_hist[r][0];
                r_hist[r][0] <= w_col_now[r];
            end
            // Accept implies S1 is empty or moving into S2 this same edge.
            r_s1_valid <= w_win_done;
            if (w_win_done) begin
                for (int k = 0; k < NUM_TAPS; k++) r_win[k] <= w_win_nxt[k];
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_comb begin
        w_sum_raw = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_sum_raw = w_sum_raw + SW'(prod_flat[tap_lo(k, PW) +: PW]);
        end
    end

`ifdef CONV_SAT_EN
    assign w_sum = (|w_sum_raw[SW-1:PW]) ? SW'({PW{1'b1}}) : w_sum_raw;
`else
    assign w_sum = w_sum_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_sum      <= w_sum;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_pack
        assign win_flat[tap_lo(g, DW) +: DW] = r_win[g];
        assign wt_flat[tap_lo(g, DW) +: DW]  = r_wt[g];
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_sum;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_scheduler.sv
// ============================================================================
// Module  : tb_conv3x3_scheduler
// Purpose : Self-checking bench for conv3x3_scheduler on a 4x4 image with a
//           behavioural multiplier layer and a window-sum reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv3x3_scheduler;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;
    localparam int PW = 32;
    localparam int SW = 36;
    localparam int NP = W * H;
    localparam int NO = (W - 2) * (H - 2);

    logic            clk = 1'b0;
    logic            rst, start, w_we, in_valid, in_ready, out_valid, out_ready;
    logic            busy, frame_done;
    logic [3:0]      w_addr;
    logic [DW-1:0]   w_data, in_data;
    logic [9*DW-1:0] win_flat, wt_flat;
    logic [9*PW-1:0] prod_flat;
    logic [SW-1:0]   out_data;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] pix [NP];
    logic [DW-1:0] mw  [9];
    logic [SW-1:0] expq [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 9; g++) begin : g_mul
        assign prod_flat[g*PW +: PW] = PW'(win_flat[g*DW +: DW]) * PW'(wt_flat[g*DW +: DW]);
    end

    conv3x3_scheduler #(.IMG_W(W), .IMG_H(H), .DW(DW), .PW(PW), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .win_flat   (win_flat),
        .wt_flat    (wt_flat),
        .prod_flat  (prod_flat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Window sum for the window whose newest pixel sits at (r,c).
    function automatic logic [SW-1:0] ref_win(input int r, input int c);
        longint unsigned s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += longint'(pix[(r-2+dr)*W + (c-2+dc)]) * longint'(mw[dr*3+dc]);
`ifdef CONV_SAT_EN
        if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
        return SW'(s);
    endfunction

    task automatic build_exp();
        expq.delete();
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                expq.push_back(ref_win(r, c));
    endtask

    task automatic write_w(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        w_we = 1'b1; w_addr = 4'(a); w_data = d;
        if (a < 9) mw[a] = d;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic check_weights();
        for (int k = 0; k < 9; k++) check("wt_tap", 64'(wt_flat[k*DW +: DW]), 64'(mw[k]));
    endtask

    // mode 0: always ready; 1: random valid/ready; 2: stall output after first result
    task automatic run_frame(input int mode, input bit wrun);
        int pi = 0, got = 0, cyc = 0, hold = 0;
        bit fd = 0, holding;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 check("busy_run", 64'(busy), 64'd1);
        while (!fd && cyc < 2000) begin
            in_valid = (pi < NP) && (mode != 1 || $urandom_range(0, 3) != 0);
            in_data  = (pi < NP) ? pix[pi] : DW'($urandom);
            holding  = (mode == 2) && (got == 0) && out_valid && (hold < 12);
            out_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : !holding;
            w_we = wrun; w_addr = 4'd4; w_data = 16'd7;
            #1;
            if (holding) begin
                hold++;
                check("held_data", 64'(out_data), 64'(expq[0]));
                if (hold == 12) check("in_ready_stall", 64'(in_ready), 64'd0);
            end
            if (in_valid && in_ready) pi++;
            if (out_valid && out_ready) begin
                got++;
                if (expq.size() == 0) check("extra_out", 64'(got), 64'(NO));
                else check("out_data", 64'(out_data), 64'(expq.pop_front()));
            end
            if (frame_done) fd = 1;
            @(negedge clk);
            cyc++;
        end
        w_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("frame_done_seen", 64'(fd), 64'd1);
        check("pixels_accepted", 64'(pi), 64'(NP));
        check("results_count", 64'(got), 64'(NO));
        #1;
        check("busy_after", 64'(busy), 64'd0);
        check("done_one_cycle", 64'(frame_done), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) mw[k] = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_win_flat", 64'(|win_flat), 64'd0);
        check("rst_wt_flat", 64'(|wt_flat), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Unit weights over pixels 1..16
        for (int i = 0; i < NP; i++) pix[i] = DW'(i + 1);
        for (int k = 0; k < 9; k++) write_w(k, 16'd1);
        check_weights();
        build_exp();
        check("model_first", 64'(expq[0]), 64'd54);
        run_frame(0, 1'b0);

        // Centre weight only
        for (int k = 0; k < 9; k++) write_w(k, (k == 4) ? 16'd2 : 16'd0);
        build_exp();
        run_frame(0, 1'b0);

        // Output stall after the first result
        for (int k = 0; k < 9; k++) write_w(k, 16'd1);
        build_exp();
        run_frame(2, 1'b0);

        // Weight writes to an out-of-range index or during RUN are dropped
        write_w(12, 16'h1234);
        check_weights();
        build_exp();
        run_frame(0, 1'b1);
        check_weights();

        // Full-scale operands
        for (int i = 0; i < NP; i++) pix[i] = 16'hFFFF;
        for (int k = 0; k < 9; k++) write_w(k, 16'hFFFF);
        build_exp();
`ifdef CONV_SAT_EN
        check("model_max", 64'(expq[0]), 64'h0_FFFF_FFFF);
`else
        check("model_max", 64'(expq[0]), 64'h8_FFEE_0009);
`endif
        run_frame(0, 1'b0);

        // Reset part-way through a frame
        for (int i = 0; i < NP; i++) pix[i] = DW'(i + 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = pix[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 9; k++) mw[k] = '0;
        check_weights();
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 9; k++) write_w(k, 16'd1);
        build_exp();
        run_frame(0, 1'b0);

        // Random frames with random handshakes
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NP; i++) pix[i] = DW'($urandom);
            for (int k = 0; k < 9; k++) write_w(k, DW'($urandom));
            build_exp();
            run_frame(1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv3x3_scheduler.md
Name: conv3x3_scheduler

Overview:
- Sequences one 3x3 convolution frame through the existing nine-lane multiplier layer.
- Accepts a raster pixel stream and keeps two line buffers to form 3x3 windows.
- Drives the nine window taps and nine stored weights into the multiplier layer, then sums the nine returned products into one result per valid window.
- Sits between the pixel source and the downstream consumer.

Parameters:
- IMG_W, 8, pixels per row (>=3)
- IMG_H, 8, rows per frame (>=3)
- DW, 16, pixel/weight width (matches multiplier lanes)
- PW, 32, product width (2*DW)
- SW, 36, result width (PW+4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a frame when IDLE, ignored otherwise
- w_we  in  1  weight write strobe
- w_addr  in  4  weight index 0..8; 9..15 ignored
- w_data  in  DW  weight value
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accept
- in_data  in  DW  pixel, raster order
- win_flat  out  9*DW  taps to multiplier inputs in1..in9; tap k at [k*DW-1:(k-1)*DW]
- wt_flat  out  9*DW  weights to multiplier w1..w9, same packing
- prod_flat  in  9*PW  products out1..out9 from multiplier layer (combinational)
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_data  out  SW  sum of nine products
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Arithmetic: all unsigned. Tap 1 is top-left (oldest row, oldest column); tap 9 is the newest pixel.
- Reset: state IDLE; all weights 0; window, counters and line buffers cleared. in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0; win_flat and wt_flat = 0.
- FSM IDLE: w_we writes weight[w_addr], effective next cycle. start -> RUN with col=row=0.
- FSM RUN: w_we ignored. Pixel accepted on in_valid&&in_ready; col/row advance, and col wraps to 0 at IMG_W-1 with row++.
  - Acceptance of pixel IMG_W*IMG_H-1 -> DRAIN.
- FSM DRAIN: wait until both pipeline stages are empty, then -> IDLE with frame_done=1 for one cycle.
- Window valid when the accepted pixel has row>=2 and col>=2. Output count is (IMG_W-2)*(IMG_H-2); there is no padding.
- Pipeline, two stages:
  - S1: window register plus a valid bit. It loads on accept of a window-completing pixel; win_flat is driven from S1.
  - S2: out_data = sum of prod_flat, registered when S1 is valid and S2 is empty or consumed.
  - Latency: pixel accepted at edge N -> out_valid high after edge N+1.
- Backpressure:
  - S1 advances only when S2 is free.
  - in_ready = (state==RUN) && (!S1_valid || S2 free).
  - While out_valid && !out_ready, out_data is held stable.
- Shift-only pixels (those not completing a window) still require in_ready; S1 valid is cleared for them.
- start during RUN/DRAIN is ignored.
- rst mid-frame: immediate return to reset values; a partial frame is discarded.

Optional Feature:
- Macro: CONV_SAT_EN.
- Defined: sum saturates at 2^32-1, so out_data[SW-1:32]=0 always and out_data = min(sum, 0xFFFFFFFF).
- Undefined: full SW-bit sum, never overflows.

Decomposition:
- Package conv_pkg holds:
  - DW/PW/SW defaults
  - state encoding (IDLE, RUN, DRAIN)
  - tap index constants
  - the flat-packing helper for tap k
- Sub-module conv_line_buffer: IMG_W-deep shift buffer of DW bits with a shift-enable input, instantiated twice.
- Adder tree stays inside the scheduler.

Test Plan:
- IMG_W=IMG_H=4, all weights 1, pixels 1..16, out_ready=1 -> outputs 54, 63, 90, 99 in order, then frame_done pulse; 16 pixels accepted.
- Same stream, weight[4]=2, all other weights 0 -> outputs 12, 14, 20, 22.
- Backpressure: hold out_ready=0 after the first result -> out_data stays 54, in_ready drops once S1 is full, no result lost; release -> remaining 63, 90, 99.
- All pixels and weights 0xFFFF -> each result 0x8FFEE0009 without CONV_SAT_EN, 0x0FFFFFFFF with it.
- w_we during RUN with w_addr=4, w_data=7 -> ignored, results unchanged; w_addr=12 in IDLE -> no weight changes.
- rst asserted after 7 pixels -> in_ready=0, out_valid=0, busy=0, weights 0; a new start plus a full frame yields the correct results.
